// File: rtl/ps_linebuffer.sv
// ps_linebuffer
//    Three-row line buffer feeding a 3x3 window stage. Rows are streamed from
//    the preprocess output FIFO into three rotating line RAMs. Once two rows
//    are buffered, every accepted pixel emits one window column
//    (top = oldest row, mid = previous row, bot = incoming pixel).
//
// Ports
//    i_clk, i_rstn          clock, asynchronous active-low reset
//    i_flush                synchronous frame abort (counters only, RAM kept)
//    o_rd                   FIFO read request (combinational)
//    i_data, i_valid        FIFO read data and its qualifier
//    i_empty                FIFO almost-empty flag
//    i_ready                downstream ready
//    o_top, o_mid, o_bot    window column, oldest row first
//    o_valid, o_eol, o_eof  column qualifier, last column, last column of frame
//    o_row                  window row index (only with PS_LINEBUF_ROWCNT_EN)
//
// Optional feature macro: PS_LINEBUF_ROWCNT_EN adds the o_row output.
//
// state  | meaning
// IDLE   | waiting for the FIFO to report data
// FILL   | buffering frame rows 0 and 1, no output
// STREAM | one window column out per accepted pixel until end of frame
module ps_linebuffer #(
   parameter int DATA_WIDTH   = 12,
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   output logic                  o_rd,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_empty,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_top,
   output logic [DATA_WIDTH-1:0] o_mid,
   output logic [DATA_WIDTH-1:0] o_bot,
   output logic                  o_valid,
   output logic                  o_eol,
   output logic                  o_eof
`ifdef PS_LINEBUF_ROWCNT_EN
   ,
   output logic [9:0]            o_row
`endif
);

   localparam int COL_W = (LINE_WIDTH   > 1) ? $clog2(LINE_WIDTH)   : 1;
   localparam int ROW_W = (FRAME_HEIGHT > 2) ? $clog2(FRAME_HEIGHT) : 2;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t                state;
   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [1:0]            wsel;
   logic [1:0]            wsel_next;
   logic [1:0]            top_sel;
   logic [1:0]            mid_sel;
   logic                  accept;
   logic                  col_last;
   logic                  row_last;

   logic [DATA_WIDTH-1:0] ram [0:2][0:LINE_WIDTH-1];

   assign o_rd     = ((state == FILL)   && !i_empty) ||
                     ((state == STREAM) && !i_empty && i_ready);
   // flush wins over a pixel presented in the same cycle
   assign accept   = o_rd && i_valid && !i_flush;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

   // (wsel+1)%3 holds the oldest row, (wsel+2)%3 the previous row
   always_comb begin
      wsel_next = 2'd0;
      top_sel   = 2'd0;
      mid_sel   = 2'd1;
      case (wsel)
         2'd0: begin wsel_next = 2'd1; top_sel = 2'd1; mid_sel = 2'd2; end
         2'd1: begin wsel_next = 2'd2; top_sel = 2'd2; mid_sel = 2'd0; end
         default: begin wsel_next = 2'd0; top_sel = 2'd0; mid_sel = 2'd1; end
      endcase
   end

   // RAM is intentionally unreset; reads below see the pre-write contents
   always_ff @(posedge i_clk) begin
      if (accept) ram[wsel][col] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= IDLE;
         col     <= '0;
         row     <= '0;
         wsel    <= 2'd0;
         o_top   <= '0;
         o_mid   <= '0;
         o_bot   <= '0;
         o_valid <= 1'b0;
         o_eol   <= 1'b0;
         o_eof   <= 1'b0;
`ifdef PS_LINEBUF_ROWCNT_EN
         o_row   <= 10'd0;
`endif
      end else begin
         o_valid <= 1'b0;
         o_eol   <= 1'b0;
         o_eof   <= 1'b0;
         if (i_flush) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            wsel  <= 2'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (!i_empty) state <= FILL;
               end
               FILL: begin
                  if (accept) begin
                     if (col_last) begin
                        col  <= '0;
                        row  <= row + ROW_W'(1);
                        wsel <= wsel_next;
                        if (row == ROW_W'(1)) state <= STREAM;
                     end else begin
                        col <= col + COL_W'(1);
                     end
                  end
               end
               STREAM: begin
                  if (accept) begin
                     o_top   <= ram[top_sel][col];
                     o_mid   <= ram[mid_sel][col];
                     o_bot   <= i_data;
                     o_valid <= 1'b1;
                     o_eol   <= col_last;
                     o_eof   <= col_last && row_last;
`ifdef PS_LINEBUF_ROWCNT_EN
                     o_row   <= 10'(row) - 10'd2;
`endif
                     if (col_last) begin
                        col <= '0;
                        if (row_last) begin
                           row   <= '0;
                           wsel  <= 2'd0;
                           state <= IDLE;
                        end else begin
                           row  <= row + ROW_W'(1);
                           wsel <= wsel_next;
                        end
                     end else begin
                        col <= col + COL_W'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/ps_linebuffer.md
PS_LINEBUFFER -- requirements
Module: ps_linebuffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning pixel width (RGB444 or greyscale-replicated).
REQ-002 SHALL have parameter LINE_WIDTH, default 640, meaning pixels per row.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 480, meaning rows per frame.
REQ-004 SHALL have port i_clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_flush, input, 1, synchronous frame abort.
REQ-007 SHALL have port o_rd, output, 1, read request to the preprocess output FIFO.
REQ-008 SHALL have port i_data, input, DATA_WIDTH, FIFO read data.
REQ-009 SHALL have port i_valid, input, 1, which qualifies i_data in the same cycle.
REQ-010 SHALL have port i_empty, input, 1, FIFO almost-empty flag.
REQ-011 SHALL have port i_ready, input, 1, downstream (Gaussian) ready.
REQ-012 SHALL have ports o_top, o_mid and o_bot, output, DATA_WIDTH each, the 3-row window column, oldest row first.
REQ-013 SHALL have port o_valid, output, 1, which qualifies o_top, o_mid and o_bot.
REQ-014 SHALL have ports o_eol and o_eof, output, 1 each, last-column and last-column-of-frame markers, coincident with o_valid.

Function
REQ-015 SHALL contain three LINE_WIDTH x DATA_WIDTH line RAMs; write select wsel cycles 0->1->2->0 at each row end.
REQ-016 SHALL implement FSM states IDLE, FILL and STREAM.
REQ-017 IDLE SHALL go to FILL on the first cycle with !i_empty.
REQ-018 FILL SHALL write rows 0 and 1 into RAM with no output, and go to STREAM after row 1 completes.
REQ-019 STREAM SHALL write the incoming row into RAM[wsel] and produce one output per accepted pixel.
REQ-020 o_rd SHALL be driven combinationally: !i_empty in FILL; !i_empty && i_ready in STREAM; 0 in IDLE.
REQ-021 A pixel SHALL be accepted only when i_valid=1; i_valid while o_rd=0 SHALL be ignored.
REQ-022 Column counter col SHALL cover 0..LINE_WIDTH-1, increment per accepted pixel, and wrap to 0 with a row increment on acceptance at LINE_WIDTH-1.
REQ-023 Outputs SHALL be registered with latency 1: o_top=RAM[(wsel+1)%3][col], o_mid=RAM[(wsel+2)%3][col], o_bot=i_data, o_valid=1, one cycle after acceptance.
REQ-024 o_eol SHALL be 1 with the output for col=LINE_WIDTH-1.
REQ-025 o_eof SHALL be 1 with o_eol on row FRAME_HEIGHT-1; on the following cycle the FSM SHALL return to IDLE and clear the row counter, col and wsel.
REQ-026 Each RAM location SHALL be read before it is written in the same cycle, so window data is never overwritten early.
REQ-027 When i_ready falls mid-row, acceptance SHALL stop with no loss: col holds, and o_valid=0 from the next cycle.
REQ-028 When i_empty rises mid-row, the FSM SHALL hold its state and col and resume on !i_empty.
REQ-029 i_flush SHALL take priority over acceptance: the next cycle SHALL have IDLE, counters=0, wsel=0 and o_valid=0, and RAM SHALL not be cleared.

Reset
REQ-030 Assertion of i_rstn=0 SHALL immediately force IDLE, col=0, row=0, wsel=0, o_valid=0, o_eol=0, o_eof=0 and o_top/o_mid/o_bot=0.
REQ-031 o_rd SHALL be 0 during reset, and RAM contents SHALL be left unreset.
REQ-032 Release of reset mid-frame SHALL start a fresh FILL on the next !i_empty.

Configuration
REQ-033 Macro PS_LINEBUF_ROWCNT_EN, when defined, SHALL add output o_row [9:0], the registered row index of the current output (0 for the first STREAM row, i.e. frame row 2), updated with o_valid and reset to 0.
REQ-034 When PS_LINEBUF_ROWCNT_EN is undefined, the o_row port and its logic SHALL be absent, with all other behaviour identical.

Verification (LINE_WIDTH=4, FRAME_HEIGHT=4 unless noted)
REQ-035 Bench SHALL cover fill: pixels 0..7 (rows 0,1) with i_ready=1 -> o_valid stays 0 and the state reaches STREAM after pixel 7.
REQ-036 Bench SHALL cover the first window: pixel values 8..11 (row 2) -> outputs (top,mid,bot) = (0,4,8),(1,5,9),(2,6,10),(3,7,11), each 1 cycle after acceptance, with o_eol on the last.
REQ-037 Bench SHALL cover rotation and EOF: row 3 values 12..15 -> (4,8,12)..(7,11,15), o_eof=1 on (7,11,15), then IDLE and o_rd=0.
REQ-038 Bench SHALL cover backpressure: i_ready=0 for 3 cycles at col=2 of row 2 -> o_rd=0, no o_valid, no pixel dropped, (2,6,10) emitted after i_ready returns.
REQ-039 Bench SHALL cover flush mid-row at col=1 of row 3 -> IDLE next cycle, o_valid=0, and the next frame requires a full 8-pixel FILL.
REQ-040 Bench SHALL cover async reset asserted mid-STREAM -> all outputs 0 with no clock edge, and with PS_LINEBUF_ROWCNT_EN defined, o_row=0.
